// File: rtl/cubic_seq_if.sv
// Handshake bundle for cubic_seq: sample in, f(x) result out.
// master = sample source / result consumer, slave = evaluator.
interface cubic_seq_if;
  logic [9:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] out_data;
  logic       out_ovf;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_ovf,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_ovf,
    output out_valid
  );
endinterface

// File: rtl/cubic_seq.sv
// f(x) = 0.85*x^3 + 1 evaluated over four steps
// on a single shared signed multiplier.
module cubic_seq #(
  parameter logic [9:0] CONST_K   = 10'd435,
  parameter logic [9:0] CONST_ONE = 10'd64
) (
  input  logic clk,
  input  logic rst,
  cubic_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SQ, CUB, MUL, DONE
  } state_t;

  state_t state, state_nx;

  logic [9:0] x;
  logic [9:0] sq;
  logic [9:0] cub;
  logic [9:0] out_data_q;
  logic       out_ovf_q;

  logic signed [19:0] op_a;
  logic signed [19:0] op_b;
  logic [19:0] p;
  logic ovf_sq;
  logic ovf_cub;

  // operand mux: one product per cycle
  always_comb begin
    op_a = '0;
    op_b = '0;
    unique case (state)
      SQ: begin
        op_a = {{10{x[9]}}, x};
        op_b = {{10{x[9]}}, x};
      end
      CUB: begin
        op_a = {10'b0, sq};
        op_b = {{10{x[9]}}, x};
      end
      MUL: begin
        op_a = {{10{cub[9]}}, cub};
        op_b = {10'b0, CONST_K};
      end
      default: ;
    endcase
  end

  assign p = op_a * op_b;

  assign ovf_sq  = |p[19:17];
  assign ovf_cub = (p[19:17] != 3'b000)
                && (p[19:17] != 3'b111);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.in_valid) state_nx = SQ;
      SQ:   state_nx = ovf_sq ? DONE : CUB;
      CUB:  state_nx = ovf_cub ? DONE : MUL;
      MUL:  state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x          <= '0;
      sq         <= '0;
      cub        <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) x <= bus.in_data;
        SQ: begin
          sq <= 10'(p >> 7);
          if (ovf_sq) begin
            out_data_q <= '0;
            out_ovf_q  <= 1'b1;
          end
        end
        CUB: begin
          cub <= 10'(p >> 8);
          if (ovf_cub) begin
            out_data_q <= '0;
            out_ovf_q  <= 1'b1;
          end
        end
        MUL: begin
          out_data_q <= 10'(p >> 9) + CONST_ONE;
          out_ovf_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.out_data  = out_data_q;
    bus.out_ovf   = out_ovf_q;
  end

endmodule

// File: tb/tb_cubic_seq.sv
// Self-checking bench for cubic_seq: table vectors,
// random vectors via a reference model, and reset corners.
module tb_cubic_seq;

  typedef struct {
    logic [9:0] x;
    logic [9:0] d;
    logic       ovf;
    int         lat;
    int         hold;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t sb[$];
  vec_t tab[7];

  cubic_seq_if bus ();

  cubic_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [9:0] x);
    vec_t e;
    int xi, s, q, c, cb, m, d;
    e.x = x;
    e.hold = 0;
    xi = int'($signed(x));
    s = xi * xi;
    if (s >= 131072) begin
      e.d = '0; e.ovf = 1'b1; e.lat = 1;
      return e;
    end
    q = s / 128;
    c = q * xi;
    if (c >= 131072 || c < -131072) begin
      e.d = '0; e.ovf = 1'b1; e.lat = 2;
      return e;
    end
    cb = c >>> 8;
    m = cb * 435;
    d = (m >>> 9) + 64;
    e.d = d[9:0];
    e.ovf = 1'b0;
    e.lat = 3;
    return e;
  endfunction

  task automatic run(input vec_t e, input bit junk);
    vec_t got;
    int w;
    int lat;
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_idle", int'(bus.in_ready), 1);
    bus.in_data   = e.x;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    sb.push_back(e);
    #1;
    if (!junk) bus.in_valid = 1'b0;
    lat = 0;
    do begin
      if (junk) bus.in_data = 10'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 10);
    chk("latency", lat, e.lat);
    if (bus.out_valid && sb.size() > 0) begin
      got = sb.pop_front();
      chk("out_data", int'(bus.out_data), int'(got.d));
      chk("out_ovf", int'(bus.out_ovf), int'(got.ovf));
      chk("in_ready_done", int'(bus.in_ready), 0);
      for (int i = 0; i < e.hold; i++) begin
        if (junk) bus.in_data = 10'($urandom);
        @(posedge clk);
        #1;
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_data", int'(bus.out_data), int'(got.d));
        chk("hold_in_ready", int'(bus.in_ready), 0);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("valid_drop", int'(bus.out_valid), 0);
    chk("ready_back", int'(bus.in_ready), 1);
  endtask

  initial begin
    bit seen;
    vec_t r;
    tab[0] = '{10'd128, 10'd118, 1'b0, 3, 0};
    tab[1] = '{10'h380, 10'd9,   1'b0, 3, 0};
    tab[2] = '{10'd0,   10'd64,  1'b0, 3, 0};
    tab[3] = '{10'd192, 10'd247, 1'b0, 3, 5};
    tab[4] = '{10'd384, 10'd0,   1'b1, 1, 0};
    tab[5] = '{10'd256, 10'd0,   1'b1, 2, 0};
    tab[6] = '{10'h300, 10'd653, 1'b0, 3, 1};

    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_out_ovf", int'(bus.out_ovf), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run(tab[i], 1'b0);

    r = model(10'd192);
    r.hold = 2;
    run(r, 1'b1);

    for (int i = 0; i < 8; i++) begin
      r = model(10'($urandom));
      r.hold = i % 3;
      run(r, (i % 2) == 1);
    end

    // abort an in-flight sample while in CUB
    @(negedge clk);
    bus.in_data  = 10'd128;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", int'(bus.in_ready), 1);
    chk("arst_out_valid", int'(bus.out_valid), 0);
    chk("arst_out_data", int'(bus.out_data), 0);
    chk("arst_out_ovf", int'(bus.out_ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("no_pulse_after_rst", int'(seen), 0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
